// File: rtl/pc_branch_unit.sv
// Program counter with a runtime-writable branch-target table.
// Each cycle the PC increments, holds on stall, or branches through a table entry; a taken branch to self halts it.
module pc_branch_unit #(
  parameter int D = 12,
  parameter int N = 8,
  parameter logic [D-1:0] PC_RST = '0,
  localparam int A = $clog2(N)
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         stall,
  input  logic         branch_en,
  input  logic         taken,
  input  logic [A-1:0] lut_sel,
  input  logic         wr_en,
  input  logic [A-1:0] wr_addr,
  input  logic [D-1:0] wr_data,
  input  logic         wr_abs,
  output logic [D-1:0] pc,
  output logic [D-1:0] target,
  output logic         halted
);

  typedef enum logic {RUN, HALT} state_t;

  localparam logic [A:0]   NUM = (A+1)'(N);
  localparam logic [D-1:0] ONE = D'(1);

  state_t       state_q, state_d;
  logic [D-1:0] pc_q, pc_d;
  logic [D-1:0] val_q [N];
  logic [D-1:0] val_d [N];
  logic [N-1:0] abs_q, abs_d;

  logic         sel_ok;
  logic         wr_ok;
  logic         bypass;
  logic [D-1:0] sel_val;
  logic         sel_abs;

  // A write to the entry being looked up in the same cycle is forwarded, so the branch never sees a stale entry.
  always_comb begin
    sel_ok  = ({1'b0, lut_sel} < NUM);
    wr_ok   = ({1'b0, wr_addr} < NUM);
    bypass  = wr_en && wr_ok && sel_ok && (wr_addr == lut_sel);
    sel_val = ONE;
    sel_abs = 1'b0;
    if (bypass) begin
      sel_val = wr_data;
      sel_abs = wr_abs;
    end else if (sel_ok) begin
      sel_val = val_q[lut_sel];
      sel_abs = abs_q[lut_sel];
    end
    target = sel_abs ? sel_val : pc_q + sel_val;
  end

  always_comb begin
    val_d   = val_q;
    abs_d   = abs_q;
    pc_d    = pc_q;
    state_d = state_q;
    if (wr_en && wr_ok) begin
      val_d[wr_addr] = wr_data;
      abs_d[wr_addr] = wr_abs;
    end
    if (state_q == RUN && !stall) begin
      if (branch_en && taken) begin
        pc_d = target;
        if (target == pc_q) begin
          state_d = HALT;
        end
      end else begin
        pc_d = pc_q + ONE;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q    <= PC_RST;
      state_q <= RUN;
      abs_q   <= '0;
      for (int i = 0; i < N; i++) begin
        val_q[i] <= ONE;
      end
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
      abs_q   <= abs_d;
      val_q   <= val_d;
    end
  end

  assign pc     = pc_q;
  assign halted = (state_q == HALT);

endmodule

// File: tb/tb_pc_branch_unit.sv
// Self-checking bench for pc_branch_unit: directed scenarios plus a random mix,
// all scored against an independent reference model through an expectation queue.
module tb_pc_branch_unit;

  logic        Clk = 1'b0;
  logic        Reset, stall, branch_en, taken, wr_en, wr_abs;
  logic [2:0]  lut_sel, wr_addr;
  logic [11:0] wr_data;
  logic [11:0] pc, target;
  logic        halted;

  always #5 Clk = ~Clk;

  pc_branch_unit dut (
    .Clk(Clk), .Reset(Reset), .stall(stall), .branch_en(branch_en), .taken(taken),
    .lut_sel(lut_sel), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_abs(wr_abs),
    .pc(pc), .target(target), .halted(halted)
  );

  typedef struct packed {
    logic        rst, stl, br, tk;
    logic [2:0]  sel;
    logic        we;
    logic [2:0]  wa;
    logic [11:0] wd;
    logic        wabs;
    logic        chk;
    logic [11:0] want;
    logic        want_h;
  } stim_t;

  typedef struct packed {
    logic [11:0] pc;
    logic        halted;
    logic        tv;
    logic [11:0] target;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   printed = 0;

  // reference model state
  logic [11:0] m_pc = '0;
  logic        m_h = 1'b0;
  logic        m_known = 1'b0;
  logic [11:0] m_val [8];
  logic        m_abs [8];
  logic [11:0] obs_target;

  function automatic stim_t s_idle();
    stim_t s = '0;
    return s;
  endfunction
  function automatic stim_t s_wr(int a, int d, bit ab);
    stim_t s = '0;
    s.we = 1'b1; s.wa = 3'(a); s.wd = 12'(d); s.wabs = ab;
    return s;
  endfunction
  function automatic stim_t s_br(int sel);
    stim_t s = '0;
    s.br = 1'b1; s.tk = 1'b1; s.sel = 3'(sel);
    return s;
  endfunction
  function automatic stim_t s_brwr(int sel, int a, int d, bit ab);
    stim_t s = s_br(sel);
    s.we = 1'b1; s.wa = 3'(a); s.wd = 12'(d); s.wabs = ab;
    return s;
  endfunction
  function automatic stim_t s_stall(int sel);
    stim_t s = s_br(sel);
    s.stl = 1'b1;
    return s;
  endfunction
  function automatic stim_t s_rst();
    stim_t s = s_brwr(3, 3, 999, 1'b1);
    s.rst = 1'b1;
    return s;
  endfunction
  function automatic stim_t want(stim_t s_in, int p, bit h);
    stim_t s = s_in;
    s.chk = 1'b1; s.want = 12'(p); s.want_h = h;
    return s;
  endfunction

  // Drives one cycle, advances the model, queues what the DUT must show after the edge.
  task automatic apply(input stim_t s);
    exp_t        e;
    logic [11:0] ev;
    logic        ea;
    Reset = s.rst; stall = s.stl; branch_en = s.br; taken = s.tk; lut_sel = s.sel;
    wr_en = s.we; wr_addr = s.wa; wr_data = s.wd; wr_abs = s.wabs;
    #1;
    obs_target = target;
    if (s.we && s.wa == s.sel) begin ev = s.wd; ea = s.wabs; end
    else begin ev = m_val[s.sel]; ea = m_abs[s.sel]; end
    e.tv = m_known;
    e.target = ea ? ev : 12'(m_pc + ev);
    if (s.rst) begin
      m_pc = '0; m_h = 1'b0; m_known = 1'b1;
      for (int i = 0; i < 8; i++) begin m_val[i] = 12'd1; m_abs[i] = 1'b0; end
    end else begin
      if (s.we) begin m_val[s.wa] = s.wd; m_abs[s.wa] = s.wabs; end
      if (!m_h && !s.stl) begin
        if (s.br && s.tk) begin
          if (e.target == m_pc) m_h = 1'b1;
          m_pc = e.target;
        end else begin
          m_pc = m_pc + 12'd1;
        end
      end
    end
    e.pc = m_pc; e.halted = m_h;
    exp_q.push_back(e);
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    stim_t st[$];
    exp_t  e;
    st.push_back(want(s_rst(), 0, 0));
    for (int i = 1; i <= 5; i++) st.push_back(want(s_idle(), i, 0));
    foreach (st[i]) begin
      apply(st[i]);
      e = exp_q.pop_front();
      checks++;
      if (pc !== e.pc || halted !== e.halted || (e.tv && obs_target !== e.target)) begin
        failures++;
        $display("[TB] FAIL reset step %0d: pc=%h halted=%b target=%h, expected pc=%h halted=%b target=%h",
                 i, pc, halted, obs_target, e.pc, e.halted, e.target);
      end
      if (st[i].chk) begin
        checks++;
        if (pc !== st[i].want || halted !== st[i].want_h) begin
          failures++;
          $display("[TB] FAIL reset_const step %0d: pc=%h halted=%b, expected pc=%h halted=%b",
                   i, pc, halted, st[i].want, st[i].want_h);
        end
      end
    end
  endtask

  task automatic test_branch();
    stim_t st[$];
    exp_t  e;
    st.push_back(s_wr(3, 'hFE6, 0));
    st.push_back(s_wr(7, 100, 1));
    st.push_back(want(s_br(7), 100, 0));
    st.push_back(want(s_br(3), 74, 0));
    st.push_back(s_wr(5, 130, 1));
    st.push_back(want(s_br(5), 130, 0));
    begin stim_t t = s_br(5); t.br = 1'b0; st.push_back(want(t, 131, 0)); end
    begin stim_t t = s_br(5); t.tk = 1'b0; st.push_back(want(t, 132, 0)); end
    foreach (st[i]) begin
      apply(st[i]);
      e = exp_q.pop_front();
      checks++;
      if (pc !== e.pc || halted !== e.halted || (e.tv && obs_target !== e.target)) begin
        failures++;
        $display("[TB] FAIL branch step %0d: pc=%h halted=%b target=%h, expected pc=%h halted=%b target=%h",
                 i, pc, halted, obs_target, e.pc, e.halted, e.target);
      end
      if (st[i].chk) begin
        checks++;
        if (pc !== st[i].want || halted !== st[i].want_h) begin
          failures++;
          $display("[TB] FAIL branch_const step %0d: pc=%h halted=%b, expected pc=%h halted=%b",
                   i, pc, halted, st[i].want, st[i].want_h);
        end
      end
    end
  endtask

  task automatic test_wrap();
    stim_t st[$];
    exp_t  e;
    st.push_back(s_wr(7, 'hFFF, 1));
    st.push_back(want(s_br(7), 'hFFF, 0));
    st.push_back(want(s_idle(), 0, 0));
    st.push_back(s_wr(6, 'hFFB, 0));
    st.push_back(s_wr(7, 4, 1));
    st.push_back(want(s_br(7), 4, 0));
    st.push_back(want(s_br(6), 'hFFF, 0));
    foreach (st[i]) begin
      apply(st[i]);
      e = exp_q.pop_front();
      checks++;
      if (pc !== e.pc || halted !== e.halted || (e.tv && obs_target !== e.target)) begin
        failures++;
        $display("[TB] FAIL wrap step %0d: pc=%h halted=%b target=%h, expected pc=%h halted=%b target=%h",
                 i, pc, halted, obs_target, e.pc, e.halted, e.target);
      end
      if (st[i].chk) begin
        checks++;
        if (pc !== st[i].want || halted !== st[i].want_h) begin
          failures++;
          $display("[TB] FAIL wrap_const step %0d: pc=%h halted=%b, expected pc=%h halted=%b",
                   i, pc, halted, st[i].want, st[i].want_h);
        end
      end
    end
  endtask

  task automatic test_bypass();
    stim_t st[$];
    exp_t  e;
    st.push_back(s_wr(7, 10, 1));
    st.push_back(want(s_br(7), 10, 0));
    st.push_back(want(s_brwr(2, 2, 22, 0), 32, 0));
    st.push_back(want(s_stall(2), 32, 0));
    st.push_back(want(s_brwr(2, 1, 500, 1), 54, 0));
    st.push_back(want(s_br(1), 500, 0));
    foreach (st[i]) begin
      apply(st[i]);
      e = exp_q.pop_front();
      checks++;
      if (pc !== e.pc || halted !== e.halted || (e.tv && obs_target !== e.target)) begin
        failures++;
        $display("[TB] FAIL bypass step %0d: pc=%h halted=%b target=%h, expected pc=%h halted=%b target=%h",
                 i, pc, halted, obs_target, e.pc, e.halted, e.target);
      end
      if (st[i].chk) begin
        checks++;
        if (pc !== st[i].want || halted !== st[i].want_h) begin
          failures++;
          $display("[TB] FAIL bypass_const step %0d: pc=%h halted=%b, expected pc=%h halted=%b",
                   i, pc, halted, st[i].want, st[i].want_h);
        end
      end
    end
  endtask

  task automatic test_halt();
    stim_t st[$];
    exp_t  e;
    st.push_back(s_wr(0, 0, 0));
    st.push_back(s_wr(7, 40, 1));
    st.push_back(want(s_br(7), 40, 0));
    st.push_back(want(s_br(0), 40, 1));
    st.push_back(want(s_idle(), 40, 1));
    st.push_back(want(s_br(7), 40, 1));
    st.push_back(want(s_wr(3, 7, 1), 40, 1));
    st.push_back(want(s_stall(3), 40, 1));
    st.push_back(want(s_rst(), 0, 0));
    st.push_back(want(s_br(0), 1, 0));
    st.push_back(want(s_br(3), 2, 0));
    foreach (st[i]) begin
      apply(st[i]);
      e = exp_q.pop_front();
      checks++;
      if (pc !== e.pc || halted !== e.halted || (e.tv && obs_target !== e.target)) begin
        failures++;
        $display("[TB] FAIL halt step %0d: pc=%h halted=%b target=%h, expected pc=%h halted=%b target=%h",
                 i, pc, halted, obs_target, e.pc, e.halted, e.target);
      end
      if (st[i].chk) begin
        checks++;
        if (pc !== st[i].want || halted !== st[i].want_h) begin
          failures++;
          $display("[TB] FAIL halt_const step %0d: pc=%h halted=%b, expected pc=%h halted=%b",
                   i, pc, halted, st[i].want, st[i].want_h);
        end
      end
    end
  endtask

  task automatic test_random();
    stim_t s;
    exp_t  e;
    for (int i = 0; i < 10000; i++) begin
      s = '0;
      s.rst  = ($urandom_range(299) == 0);
      s.stl  = ($urandom_range(7) == 0);
      s.br   = ($urandom_range(2) == 0);
      s.tk   = ($urandom_range(1) == 0);
      s.sel  = 3'($urandom_range(7));
      s.we   = ($urandom_range(3) == 0);
      s.wa   = 3'($urandom_range(7));
      s.wd   = ($urandom_range(3) == 0) ? 12'(0) : 12'($urandom_range(4095));
      s.wabs = ($urandom_range(1) == 0);
      apply(s);
      e = exp_q.pop_front();
      checks++;
      if (pc !== e.pc || halted !== e.halted || (e.tv && obs_target !== e.target)) begin
        failures++;
        if (printed < 20) begin
          printed++;
          $display("[TB] FAIL random cycle %0d: pc=%h halted=%b target=%h, expected pc=%h halted=%b target=%h",
                   i, pc, halted, obs_target, e.pc, e.halted, e.target);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin m_val[i] = 12'd1; m_abs[i] = 1'b0; end
    test_reset();
    test_branch();
    test_wrap();
    test_bypass();
    test_halt();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
